// File: rtl/dot_vec_mac.sv
// Signed fixed-point dot-product MAC: lane multiply, registered adder tree,
// multi-beat group accumulation, round-half-up and saturate to DW bits.
module dot_vec_mac #(
    parameter int LANES = 25,
    parameter int DW    = 16,
    parameter int FRAC  = 8,
    parameter int ACC_W = 48
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic                  in_last,
    input  logic [LANES*DW-1:0]   in_a,
    input  logic [LANES*DW-1:0]   in_b,
    output logic                  out_valid,
    output logic [DW-1:0]         out_data,
    output logic                  out_sat,
    output logic                  busy
);

    localparam int TREE_LVL = $clog2(LANES);
    localparam int TW       = 2*DW + TREE_LVL;
    localparam int RW       = ACC_W + 1;

    function automatic int cnt(input int l);
        int n;
        n = LANES;
        for (int i = 0; i < l; i++) n = (n + 1) / 2;
        return n;
    endfunction

    // Bit offset of tree level l inside the flat tree register
    function automatic int off(input int l);
        int o;
        o = 0;
        for (int i = 0; i < l; i++) o += cnt(i) * TW;
        return o;
    endfunction

    localparam int TOT     = off(TREE_LVL + 1);
    localparam int SUM_OFF = off(TREE_LVL);

    localparam logic signed [RW-1:0] SMAX =
        {{(RW-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [RW-1:0] SMIN =
        {{(RW-DW+1){1'b1}}, {(DW-1){1'b0}}};

    logic [TOT-1:0]          r_tree;
    logic [TOT-1:0]          w_tree;
    logic [TREE_LVL:0]       r_v;
    logic [TREE_LVL:0]       r_l;
    logic [2*DW-1:0]         w_ea;
    logic [2*DW-1:0]         w_eb;
    logic [2*DW-1:0]         w_prod;
    logic signed [TW-1:0]    w_sum;
    logic signed [ACC_W-1:0] w_sum_x;
    logic signed [ACC_W-1:0] r_acc;
    logic                    r_open;
    logic                    r_av;
    logic signed [RW-1:0]    w_accx;
    logic signed [RW-1:0]    w_rnd;
    logic signed [RW-1:0]    r_rnd;
    logic                    r_rv;
    logic                    r_ov;
    logic [DW-1:0]           r_data;
    logic                    r_sat;

    // Level 0 is the product row; each further level halves the element count
    always_comb begin
        w_tree = '0;
        w_ea   = '0;
        w_eb   = '0;
        w_prod = '0;
        for (int k = 0; k < LANES; k++) begin
            w_ea   = {{DW{in_a[k*DW+DW-1]}}, in_a[k*DW +: DW]};
            w_eb   = {{DW{in_b[k*DW+DW-1]}}, in_b[k*DW +: DW]};
            w_prod = w_ea * w_eb;
            w_tree[k*TW +: TW] = {{(TW-2*DW){w_prod[2*DW-1]}}, w_prod};
        end
        for (int l = 1; l <= TREE_LVL; l++) begin
            for (int j = 0; j < LANES; j++) begin
                if (j < cnt(l)) begin
                    if (2*j + 1 < cnt(l-1))
                        w_tree[off(l)+j*TW +: TW] =
                            r_tree[off(l-1)+2*j*TW +: TW] +
                            r_tree[off(l-1)+(2*j+1)*TW +: TW];
                    else
                        w_tree[off(l)+j*TW +: TW] =
                            r_tree[off(l-1)+2*j*TW +: TW];
                end
            end
        end
    end

    assign w_sum   = r_tree[SUM_OFF +: TW];
    assign w_sum_x = ACC_W'(w_sum);
    assign w_accx  = RW'(r_acc);

    generate
        if (FRAC > 0) begin : g_rnd
            localparam logic signed [RW-1:0] HALF = RW'(1) << (FRAC - 1);
            assign w_rnd = (w_accx + HALF) >>> FRAC;
        end else begin : g_nornd
            assign w_rnd = w_accx;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_tree <= '0;
            r_v    <= '0;
            r_l    <= '0;
            r_acc  <= '0;
            r_open <= 1'b0;
            r_av   <= 1'b0;
            r_rnd  <= '0;
            r_rv   <= 1'b0;
            r_ov   <= 1'b0;
            r_data <= '0;
            r_sat  <= 1'b0;
        end else begin
            r_tree <= w_tree;
            r_v    <= {r_v[TREE_LVL-1:0], in_valid};
            r_l    <= {r_l[TREE_LVL-1:0], in_valid & in_last};
            r_av   <= r_v[TREE_LVL] & r_l[TREE_LVL];
            if (r_v[TREE_LVL]) begin
                r_acc  <= r_open ? r_acc + w_sum_x : w_sum_x;
                r_open <= ~r_l[TREE_LVL];
            end
            r_rv <= r_av;
            if (r_av) r_rnd <= w_rnd;
            r_ov <= r_rv;
            if (r_rv) begin
                if (r_rnd > SMAX) begin
                    r_data <= SMAX[DW-1:0];
                    r_sat  <= 1'b1;
                end else if (r_rnd < SMIN) begin
                    r_data <= SMIN[DW-1:0];
                    r_sat  <= 1'b1;
                end else begin
                    r_data <= r_rnd[DW-1:0];
                    r_sat  <= 1'b0;
                end
            end
        end
    end

    assign out_valid = r_ov;
    assign out_data  = r_data;
    assign out_sat   = r_sat;
    assign busy      = r_open | (|r_v) | r_av | r_rv | r_ov;

endmodule

// File: tb/tb_dot_vec_mac.sv
// Directed bench for dot_vec_mac at default parameters.
module tb_dot_vec_mac;

    localparam int LANES = 25;
    localparam int DW    = 16;
    localparam int LAT   = 8;

    logic                clk;
    logic                rst_n;
    logic                in_valid;
    logic                in_last;
    logic [LANES*DW-1:0] in_a;
    logic [LANES*DW-1:0] in_b;
    logic                out_valid;
    logic [DW-1:0]       out_data;
    logic                out_sat;
    logic                busy;

    dot_vec_mac #(.LANES(25), .DW(16), .FRAC(8), .ACC_W(48)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_sat   (out_sat),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_err = 0;
    int q_cyc[$];
    int q_dat[$];
    int q_sat[$];
    int va[LANES];
    int vb[LANES];

    always @(negedge clk) begin
        if (out_valid) begin
            q_cyc.push_back(cyc);
            q_dat.push_back(int'($signed(out_data)));
            q_sat.push_back(int'(out_sat));
        end
    end

    task automatic chk(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic beat(input bit l, output int e);
        for (int k = 0; k < LANES; k++) begin
            in_a[k*DW +: DW] = DW'(va[k]);
            in_b[k*DW +: DW] = DW'(vb[k]);
        end
        in_valid = 1'b1;
        in_last  = l;
        @(posedge clk);
        #1;
        e        = cyc;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        in_last  = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_pulse(input string tag, input int e,
                                input int d, input int s);
        int t;
        t = 0;
        while (q_cyc.size() == 0 && t < 40) begin
            @(negedge clk);
            t++;
        end
        if (q_cyc.size() == 0) begin
            chk({tag, "_pulse"}, q_cyc.size(), 1);
        end else begin
            chk({tag, "_lat"}, q_cyc.pop_front() - e, LAT);
            chk({tag, "_data"}, q_dat.pop_front(), d);
            chk({tag, "_sat"}, q_sat.pop_front(), s);
        end
    endtask

    task automatic fill(input int mode, input int bval);
        for (int k = 0; k < LANES; k++) begin
            case (mode)
                0:       va[k] = k;
                1:       va[k] = -k;
                default: va[k] = (k < 13) ? -k : k;
            endcase
            vb[k] = bval;
        end
    endtask

    task automatic fill_all(input int a, input int b);
        for (int k = 0; k < LANES; k++) begin
            va[k] = a;
            vb[k] = b;
        end
    endtask

    int e, e1, e2;
    int rnd_a[4] = '{1, 1, -1, -1};
    int rnd_b[4] = '{128, 127, 128, 129};
    int rnd_r[4] = '{1, 0, 0, -1};

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_a     = '0;
        in_b     = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_sat", out_sat, 0);
        chk("rst_busy", busy, 0);
        rst_n = 1'b1;
        idle(2);

        fill(0, 256);
        beat(1'b1, e);
        repeat (8) @(negedge clk);
        chk("t1_early", out_valid, 0);
        @(negedge clk);
        chk("t1_pulse_now", out_valid, 1);
        chk("t1_busy_hi", busy, 1);
        @(negedge clk);
        chk("t1_pulse_end", out_valid, 0);
        chk("t1_busy_lo", busy, 0);
        expect_pulse("t1", e, 300, 0);
        idle(3);
        chk("t1_hold", int'($signed(out_data)), 300);

        fill(1, 256);
        beat(1'b1, e);
        expect_pulse("t2neg", e, -300, 0);
        fill(2, 256);
        beat(1'b1, e);
        expect_pulse("t2mix", e, 144, 0);

        fill(0, 256);
        beat(1'b0, e);
        idle(2);
        beat(1'b0, e);
        beat(1'b1, e1);
        beat(1'b1, e2);
        expect_pulse("t3grp", e1, 900, 0);
        expect_pulse("t3b2b", e1 + 1, 300, 0);

        fill_all(32767, 32767);
        beat(1'b1, e);
        expect_pulse("t4max", e, 32767, 1);
        fill_all(-32768, 32767);
        beat(1'b1, e);
        expect_pulse("t4min", e, -32768, 1);

        for (int i = 0; i < 4; i++) begin
            fill_all(0, 0);
            va[0] = rnd_a[i];
            vb[0] = rnd_b[i];
            beat(1'b1, e);
            expect_pulse($sformatf("t5rnd%0d", i), e, rnd_r[i], 0);
        end

        fill(0, 256);
        beat(1'b0, e);
        beat(1'b0, e);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("t6_busy_rst", busy, 0);
        chk("t6_valid_rst", out_valid, 0);
        rst_n = 1'b1;
        beat(1'b1, e);
        expect_pulse("t6", e, 300, 0);
        idle(15);
        chk("no_extra", q_cyc.size(), 0);
        chk("idle_busy", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
